// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Feeds per-digit seg7 decoders and provides leading-zero blank flags for HEX digits.
//
// Handshake: start is sampled only in IDLE, and bin is captured on the same edge.
// busy is high from the accepting edge until the result edge. done is a
// one-cycle pulse in the cycle after busy falls, and bcd/blank already hold the
// new result in that cycle. A start seen while busy is dropped, not queued.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // state is kept as a named signal so checkers can bind to it directly
    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] scratch_adj;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   blank_next;
    logic                upper_zero;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; the counter reaching 1 marks the last shift edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // add-3 correction on every scratch digit that is 5 or more, before the shift
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // leading-zero flags: digit i is blank when it and every digit above it are zero
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            upper_zero    = upper_zero && (scratch[4*i +: 4] == 4'd0);
            blank_next[i] = upper_zero;
        end
    end

    // datapath: capture, shift, and publish the result; outputs only move on DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            blank   <= BLANK_RST;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                end
                DONE: begin
                    bcd   <= scratch;
                    blank <= blank_next;
                    done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq with hand-computed expected digits.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int checks   = 0;
    int failures = 0;

    // expected results in completion order: {blank, bcd}
    logic [24:0] exp_q[$];
    logic [19:0] prev_bcd;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        logic [24:0] e;
        if (done === 1'b1) begin
            check_eq("busy_with_done", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("bcd", 32'(bcd), 32'(e[19:0]));
                check_eq("blank", 32'(blank), 32'(e[24:20]));
            end
        end
    end

    // one conversion with latency, busy length, hold and pulse-width checks
    task automatic convert(input logic [15:0] v, input logic [19:0] eb, input logic [4:0] ebl);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        exp_q.push_back({ebl, eb});
        @(negedge clk);
        start = 1'b0;
        bin   = ~v;
        n        = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (n == 8) check_eq("hold_bcd", 32'(bcd), 32'(prev_bcd));
            @(negedge clk);
            n++;
        end
        check_eq("latency", 32'(n), 32'd17);
        check_eq("busy_cycles", 32'(busy_cnt), 32'd17);
        prev_bcd = eb;
        @(negedge clk);
        check_eq("done_width", 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        int dones;
        int last;
        logic prev_done;

        reset    = 1'b1;
        start    = 1'b0;
        bin      = '0;
        prev_bcd = '0;

        // reset then idle
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_bcd", 32'(bcd), 32'h0);
        check_eq("rst_blank", 32'(blank), 32'b11110);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_done", 32'(done), 32'd0);
            check_eq("idle_bcd", 32'(bcd), 32'h0);
        end

        // main function and boundaries
        convert(16'd1234,  20'h01234, 5'b10000);
        convert(16'd0,     20'h00000, 5'b11110);
        convert(16'd65535, 20'h65535, 5'b00000);
        convert(16'd9,     20'h00009, 5'b11110);
        convert(16'd10,    20'h00010, 5'b11100);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd500;
        exp_q.push_back({5'b11000, 20'h00500});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 16'd42;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_done_seen");
        repeat (30) @(negedge clk);
        check_eq("ignore_idle", 32'(busy), 32'd0);
        check_eq("ignore_bcd", 32'(bcd), 32'h00500);

        // reset mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd777;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_bcd", 32'(bcd), 32'h0);
        check_eq("midrst_blank", 32'(blank), 32'b11110);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("midrst_idle", 32'(busy), 32'd0);
        prev_bcd = '0;
        convert(16'd777, 20'h00777, 5'b11000);

        // start held high: back-to-back conversions, bin changed mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd321;
        exp_q.push_back({5'b11000, 20'h00321});
        exp_q.push_back({5'b11000, 20'h00321});
        exp_q.push_back({5'b11000, 20'h00321});
        exp_q.push_back({5'b11100, 20'h00088});
        n         = 0;
        dones     = 0;
        last      = -1;
        prev_done = 1'b0;
        while (dones < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (prev_done) check_eq("held_done_width", 32'(done), 32'd0);
            prev_done = done;
            if (done === 1'b1) begin
                dones++;
                if (last >= 0) check_eq("held_period", 32'(n - last), 32'd18);
                last = n;
                if (dones == 4) start = 1'b0;
            end
            if (dones == 2 && n == last + 5) bin = 16'd88;
        end
        check_eq("held_dones", 32'(dones), 32'd4);
        @(negedge clk);
        check_eq("held_last_width", 32'(done), 32'd0);
        repeat (25) @(negedge clk);
        check_eq("held_idle", 32'(busy), 32'd0);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
